// File: rtl/halfbridge_duty_ctrl.sv
// Soft-start / fault sequencer owning the half-bridge duty word.
// Duty ramps toward a clamped target once per synchronized clk_int rising edge.
module halfbridge_duty_ctrl #(
    parameter int unsigned STEP = 4,
    parameter int unsigned DMAX = 900
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       clk_int,
    input  logic       enable,
    input  logic [9:0] d_target,
    input  logic       fault,
    output logic [9:0] d_halfbridge,
    output logic       gate_en,
    output logic [1:0] state,
    output logic       fault_latched,
    output logic       at_target
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] DMAX_W = 11'(DMAX);
    localparam logic [9:0]  DMAX_V = 10'(DMAX);

    logic       int_s1_q, int_s2_q, int_s3_q;
    logic       flt_s1_q, flt_s2_q;
    logic       tick;
    state_t     state_q, state_d;
    logic [9:0] duty_q, duty_d;
    logic [9:0] tgt_q, tgt_d;
    logic       gate_en_q, gate_en_d;
    logic       at_target_q, at_target_d;
    logic       fault_latched_q, fault_latched_d;

    function automatic logic [9:0] clamp_tgt(input logic en, input logic [9:0] req);
        if (!en) begin
            return 10'd0;
        end else if ({1'b0, req} > DMAX_W) begin
            return DMAX_V;
        end else begin
            return req;
        end
    endfunction

    // Widened to 11 bits so neither direction can wrap past 0 or 1023.
    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] cur_w, tgt_w, up_w, nxt_w;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        up_w  = cur_w + STEP_W;
        if (cur_w < tgt_w) begin
            nxt_w = (up_w > tgt_w) ? tgt_w : up_w;
        end else if (cur_w > tgt_w) begin
            nxt_w = (cur_w > tgt_w + STEP_W) ? (cur_w - STEP_W) : tgt_w;
        end else begin
            nxt_w = cur_w;
        end
        return nxt_w[9:0];
    endfunction

    // Synchronizers: the fault chain always runs, the tick chain freezes with ce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
            int_s3_q <= 1'b0;
            flt_s1_q <= 1'b0;
            flt_s2_q <= 1'b0;
        end else begin
            flt_s1_q <= fault;
            flt_s2_q <= flt_s1_q;
            if (ce) begin
                int_s1_q <= clk_int;
                int_s2_q <= int_s1_q;
                int_s3_q <= int_s2_q;
            end
        end
    end

    assign tick = int_s2_q & ~int_s3_q & ce;

    // Next-state: fault dominates, otherwise everything advances only on tick.
    always_comb begin
        state_d         = state_q;
        duty_d          = duty_q;
        tgt_d           = tgt_q;
        gate_en_d       = gate_en_q;
        at_target_d     = at_target_q;
        fault_latched_d = fault_latched_q;
        if (flt_s2_q) begin
            state_d = S_FAULT;
            duty_d  = 10'd0;
            tgt_d   = 10'd0;
        end else if (tick) begin
            tgt_d = clamp_tgt(enable, d_target);
            case (state_q)
                S_FAULT: begin
                    duty_d = 10'd0;
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
                default: begin
                    duty_d = step_toward(duty_q, tgt_d);
                    if (duty_d != tgt_d) begin
                        state_d = S_RAMP;
                    end else if (tgt_d != 10'd0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end else begin
            state_d = state_q;
        end
        gate_en_d       = (state_d == S_RAMP) || (state_d == S_RUN);
        at_target_d     = (state_d == S_RUN) && (duty_d == tgt_d);
        fault_latched_d = (state_d == S_FAULT);
    end

    // Output and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            duty_q          <= 10'd0;
            tgt_q           <= 10'd0;
            gate_en_q       <= 1'b0;
            at_target_q     <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            duty_q          <= duty_d;
            tgt_q           <= tgt_d;
            gate_en_q       <= gate_en_d;
            at_target_q     <= at_target_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign d_halfbridge  = duty_q;
    assign gate_en       = gate_en_q;
    assign state         = state_q;
    assign fault_latched = fault_latched_q;
    assign at_target     = at_target_q;

endmodule

// File: tb/tb_halfbridge_duty_ctrl.sv
// Bench for halfbridge_duty_ctrl: vector table, directed corner sequences and
// a randomized run against a tick-level reference model.
module tb_halfbridge_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       clk_int;
    logic       enable;
    logic [9:0] d_target;
    logic       fault;
    logic [9:0] d_hb;
    logic       gate_en;
    logic [1:0] state;
    logic       fault_latched;
    logic       at_target;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state (tick granularity)
    int m_d, m_state, m_tgt;

    typedef struct {
        logic       en;
        logic [9:0] tgt;
        int         exp_d;
        int         exp_st;
        int         exp_g;
        int         exp_at;
    } vec_t;
    vec_t tbl[14];

    halfbridge_duty_ctrl #(.STEP(4), .DMAX(900)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .clk_int      (clk_int),
        .enable       (enable),
        .d_target     (d_target),
        .fault        (fault),
        .d_halfbridge (d_hb),
        .gate_en      (gate_en),
        .state        (state),
        .fault_latched(fault_latched),
        .at_target    (at_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input int ed, input int est, input int eg,
                            input int efl, input int eat);
        chk({nm, "_d"}, int'(d_hb), ed);
        chk({nm, "_state"}, int'(state), est);
        chk({nm, "_gate"}, int'(gate_en), eg);
        chk({nm, "_fl"}, int'(fault_latched), efl);
        chk({nm, "_at"}, int'(at_target), eat);
    endtask

    task automatic model_reset();
        m_d = 0;
        m_state = 0;
        m_tgt = 0;
    endtask

    task automatic model_tick(input bit en, input int req);
        if (m_state == 3) begin
            if (!en) m_state = 0;
        end else begin
            m_tgt = en ? ((req > 900) ? 900 : req) : 0;
            if (m_d < m_tgt)      m_d = (m_d + 4 > m_tgt) ? m_tgt : m_d + 4;
            else if (m_d > m_tgt) m_d = (m_d - 4 < m_tgt) ? m_tgt : m_d - 4;
            if (m_d != m_tgt)     m_state = 1;
            else if (m_tgt > 0)   m_state = 2;
            else                  m_state = 0;
        end
    endtask

    task automatic chk_model(input string nm);
        chk_outs(nm, m_d, m_state, (m_state == 1 || m_state == 2) ? 1 : 0,
                 (m_state == 3) ? 1 : 0, (m_state == 2 && m_d == m_tgt) ? 1 : 0);
        chk({nm, "_dmax"}, (d_hb > 10'd900) ? 1 : 0, 0);
        chk({nm, "_off0"}, (!gate_en && d_hb != 10'd0) ? 1 : 0, 0);
    endtask

    // One full clk_int period; returns #1 after a clock edge.
    task automatic pulse_int();
        @(posedge clk); #1 clk_int = 1'b1;
        repeat (6) @(posedge clk);
        #1 clk_int = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; clk_int = 1'b0; enable = 1'b0; d_target = 10'd0; fault = 1'b0;
        tbl[0]  = '{1'b1, 10'd20, 4, 1, 1, 0};
        tbl[1]  = '{1'b1, 10'd20, 8, 1, 1, 0};
        tbl[2]  = '{1'b1, 10'd20, 12, 1, 1, 0};
        tbl[3]  = '{1'b1, 10'd20, 16, 1, 1, 0};
        tbl[4]  = '{1'b1, 10'd20, 20, 2, 1, 1};
        tbl[5]  = '{1'b0, 10'd20, 16, 1, 1, 0};
        tbl[6]  = '{1'b0, 10'd20, 12, 1, 1, 0};
        tbl[7]  = '{1'b0, 10'd20, 8, 1, 1, 0};
        tbl[8]  = '{1'b0, 10'd20, 4, 1, 1, 0};
        tbl[9]  = '{1'b0, 10'd20, 0, 0, 0, 0};
        tbl[10] = '{1'b1, 10'd3, 3, 2, 1, 1};
        tbl[11] = '{1'b1, 10'd5, 5, 2, 1, 1};
        tbl[12] = '{1'b1, 10'd0, 1, 1, 1, 0};
        tbl[13] = '{1'b1, 10'd0, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1 chk_outs("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();

        // soft-start ramp 0 -> 100
        enable = 1'b1; d_target = 10'd100;
        for (int k = 1; k <= 25; k++) begin
            pulse_int();
            chk_outs($sformatf("ramp%0d", k), 4 * k, (k == 25) ? 2 : 1, 1, 0, (k == 25) ? 1 : 0);
            model_tick(1'b1, 100);
        end

        // non-multiple step and DMAX clamp
        d_target = 10'd102;
        pulse_int(); model_tick(1'b1, 102);
        chk_outs("step102", 102, 2, 1, 0, 1);
        d_target = 10'd1000;
        for (int k = 0; k < 200; k++) begin
            pulse_int(); model_tick(1'b1, 1000);
            chk_model($sformatf("clamp%0d", k));
        end
        chk_outs("clamp_end", 900, 2, 1, 0, 1);
        d_target = 10'd0;
        pulse_int(); model_tick(1'b1, 0);
        chk_outs("down896", 896, 1, 1, 0, 0);

        // vector table: ramp to 20, disable ramp-down, tiny targets
        do_reset();
        for (int i = 0; i < 14; i++) begin
            enable = tbl[i].en; d_target = tbl[i].tgt;
            pulse_int();
            chk_outs($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_st, tbl[i].exp_g, 0, tbl[i].exp_at);
        end

        // fault mid-ramp at d=48
        do_reset();
        enable = 1'b1; d_target = 10'd100;
        repeat (12) pulse_int();
        chk("pre_fault_d", int'(d_hb), 48);
        fault = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_outs("fault_in", 0, 3, 0, 1, 0);
        fault = 1'b0;
        repeat (4) @(posedge clk);
        #1 pulse_int();
        chk_outs("fault_hold_en", 0, 3, 0, 1, 0);
        enable = 1'b0;
        pulse_int();
        chk_outs("fault_exit", 0, 0, 0, 0, 0);
        enable = 1'b1;
        pulse_int();
        chk_outs("fault_reentry", 4, 1, 1, 0, 0);

        // ce low across 3 clk_int periods freezes duty
        ce = 1'b0;
        repeat (3) pulse_int();
        chk_outs("ce_hold", 4, 1, 1, 0, 0);
        ce = 1'b1;
        pulse_int();
        chk_outs("ce_resume", 8, 1, 1, 0, 0);

        // fault and tick synchronized in the same cycle
        @(posedge clk); #1 fault = 1'b1; clk_int = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk_outs("coincide", 0, 3, 0, 1, 0);
        fault = 1'b0; clk_int = 1'b0;
        repeat (6) @(posedge clk);
        #1 enable = 1'b0;
        pulse_int();
        chk_outs("coincide_exit", 0, 0, 0, 0, 0);

        // async reset mid-ramp at d=60
        enable = 1'b1; d_target = 10'd100;
        repeat (15) pulse_int();
        chk("pre_rst_d", int'(d_hb), 60);
        #2 rst = 1'b1;
        #1 chk_outs("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b0;
        d_target = 10'd60;
        pulse_int();
        chk_outs("rst_restart", 4, 1, 1, 0, 0);

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            enable = ($urandom_range(0, 9) < 8);
            d_target = 10'($urandom_range(0, 1023));
            if (r == 0) begin
                fault = 1'b1;
                repeat (4) @(posedge clk);
                #1 fault = 1'b0;
                m_d = 0; m_state = 3; m_tgt = 0;
                repeat (4) @(posedge clk);
                #1;
            end else if (r == 1) begin
                ce = 1'b0;
                pulse_int();
                ce = 1'b1;
            end else begin
                pulse_int();
                model_tick(enable, int'(d_target));
            end
            chk_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
